// File: rtl/pet_cmd_scheduler_pkg.sv
// pet_cmd_scheduler_pkg: shared state encodings, pend bit indices and test-code limits
// for the pet command scheduler.
package pet_cmd_scheduler_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_GAP, ST_TSEL, ST_TCOMMIT} state_t;
   localparam int P_PLAY  = 0;
   localparam int P_FEED  = 1;
   localparam int P_SLEEP = 2;
   localparam int P_AWAKE = 3;
   localparam logic [3:0] TC_FIRST = 4'd1;
   localparam logic [3:0] TC_LAST  = 4'd9;
   // One-hot of the highest-priority pending command (awake > sleep > feed > play).
   function automatic logic [3:0] pick_prio(input logic [3:0] pend);
      pick_prio = pend[P_AWAKE] ? 4'b1000 : pend[P_SLEEP] ? 4'b0100 :
                  pend[P_FEED]  ? 4'b0010 : pend[P_PLAY]  ? 4'b0001 : 4'b0000;
   endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, debounce and rise detect for one raw input.
module btn_conditioner #(
   parameter int DEB_CYC = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);
   localparam int CW = $clog2(DEB_CYC + 1);
   logic r_s1, r_s2, r_level, r_rise;
   logic [CW-1:0] r_cnt;
   logic w_diff, w_flip;
   assign w_diff = r_s2 ^ r_level;
   assign w_flip = w_diff && (r_cnt == CW'(DEB_CYC - 1));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_s1    <= i_raw;
         r_s2    <= r_s1;
         r_cnt   <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
         r_level <= w_flip ? ~r_level : r_level;
         r_rise  <= w_flip && !r_level;
      end
   assign o_level = r_level;
   assign o_rise  = r_rise;
endmodule

// File: rtl/pet_cmd_scheduler.sv
// pet_cmd_scheduler: conditions buttons, queues presses and issues stretched commands
// and test-mode selections to the pet core.
module pet_cmd_scheduler
   import pet_cmd_scheduler_pkg::*;
#(
   parameter int DEB_CYC      = 50000,
   parameter int CMD_HOLD     = 100000,
   parameter int GAP_CYC      = 1000,
   parameter int TSEL_TIMEOUT = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_sleep,
   input  logic       btn_awake,
   input  logic       btn_feed,
   input  logic       btn_play,
   input  logic       btn_test,
   input  logic       giro_raw,
   output logic       cmd_sleep,
   output logic       cmd_awake,
   output logic       cmd_feed,
   output logic       cmd_play,
   output logic       giro,
   output logic       test_level,
   output logic [3:0] pulse_test,
   output logic       busy
);
   localparam int HW = $clog2(CMD_HOLD + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam int TW = $clog2(TSEL_TIMEOUT + 1);
   localparam int B_TEST = 4;
   localparam int B_GIRO = 5;

   logic [5:0] w_raw, w_lvl, w_rise;
   logic       w_unused;
   state_t     r_state, w_state_n;
   logic [3:0] r_pend, w_pend_n, r_cmd, w_cmd_n, r_sel, w_sel_n, r_pulse, w_pulse_n;
   logic [3:0] w_pick, w_sel_inc, w_commit;
   logic [HW-1:0] r_hold, w_hold_n;
   logic [GW-1:0] r_gap, w_gap_n;
   logic [TW-1:0] r_tout, w_tout_n;
   logic       r_test, r_busy;

   // Bits 3:0 line up with the pend vector so rises can be OR-ed in directly.
   assign w_raw[P_PLAY]  = btn_play;
   assign w_raw[P_FEED]  = btn_feed;
   assign w_raw[P_SLEEP] = btn_sleep;
   assign w_raw[P_AWAKE] = btn_awake;
   assign w_raw[B_TEST]  = btn_test;
   assign w_raw[B_GIRO]  = giro_raw;

   for (genvar i = 0; i < 6; i++) begin : g_btn
      btn_conditioner #(.DEB_CYC(DEB_CYC)) u_btn (
         .clk(clk), .rst(rst), .i_raw(w_raw[i]), .o_level(w_lvl[i]), .o_rise(w_rise[i])
      );
   end
   assign w_unused = ^{w_lvl[4:0], w_rise[B_GIRO]};

   assign w_pick    = pick_prio(r_pend);
   assign w_sel_inc = (r_sel == TC_LAST) ? TC_FIRST : r_sel + 4'd1;
   // A feed and awake in the same cycle commit the already-incremented code.
   assign w_commit  = w_rise[P_FEED] ? w_sel_inc : r_sel;

   always_comb begin
      w_state_n = r_state;
      w_pend_n  = (r_state == ST_TSEL || r_state == ST_TCOMMIT) ? r_pend : r_pend | w_rise[3:0];
      w_cmd_n   = r_cmd;
      w_sel_n   = r_sel;
      w_pulse_n = r_pulse;
      w_hold_n  = r_hold;
      w_gap_n   = r_gap;
      w_tout_n  = r_tout;
      case (r_state)
         ST_IDLE:
            if (w_rise[B_TEST]) begin
               w_state_n = ST_TSEL;
               w_pend_n  = '0;
               w_sel_n   = '0;
               w_tout_n  = '0;
            end else if (|r_pend) begin
               w_state_n = ST_ISSUE;
               w_pend_n  = w_pend_n & ~w_pick;
               w_cmd_n   = w_pick;
               w_hold_n  = HW'(CMD_HOLD - 1);
            end
         ST_ISSUE:
            if (r_hold == '0) begin
               w_state_n = ST_GAP;
               w_cmd_n   = '0;
               w_gap_n   = GW'(GAP_CYC - 1);
            end else w_hold_n = r_hold - 1'b1;
         ST_GAP:
            if (r_gap == '0) w_state_n = ST_IDLE;
            else w_gap_n = r_gap - 1'b1;
         ST_TSEL:
            if (w_rise[P_AWAKE] && w_commit != '0) begin
               w_state_n = ST_TCOMMIT;
               w_pulse_n = w_commit;
               w_hold_n  = HW'(CMD_HOLD - 1);
            end else if (w_rise[P_FEED] || w_rise[P_AWAKE]) begin
               w_sel_n  = w_commit;
               w_tout_n = '0;
            end else if (r_tout == TW'(TSEL_TIMEOUT - 1)) begin
               w_state_n = ST_TCOMMIT;
               w_pulse_n = TC_FIRST;
               w_hold_n  = HW'(CMD_HOLD - 1);
            end else w_tout_n = r_tout + 1'b1;
         ST_TCOMMIT:
            if (r_hold == '0) begin
               w_state_n = ST_IDLE;
               w_pulse_n = '0;
            end else w_hold_n = r_hold - 1'b1;
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= ST_IDLE;
         r_pend  <= '0;
         r_cmd   <= '0;
         r_sel   <= '0;
         r_pulse <= '0;
         r_hold  <= '0;
         r_gap   <= '0;
         r_tout  <= '0;
         r_test  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pend  <= w_pend_n;
         r_cmd   <= w_cmd_n;
         r_sel   <= w_sel_n;
         r_pulse <= w_pulse_n;
         r_hold  <= w_hold_n;
         r_gap   <= w_gap_n;
         r_tout  <= w_tout_n;
         r_test  <= (w_state_n == ST_TSEL);
         r_busy  <= (w_state_n != ST_IDLE);
      end

   assign cmd_sleep  = r_cmd[P_SLEEP];
   assign cmd_awake  = r_cmd[P_AWAKE];
   assign cmd_feed   = r_cmd[P_FEED];
   assign cmd_play   = r_cmd[P_PLAY];
   assign giro       = w_lvl[B_GIRO];
   assign test_level = r_test;
   assign pulse_test = r_pulse;
   assign busy       = r_busy;
endmodule
